// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator
//   Consumer end of the radix-4 Booth digit interface. It latches a signed
//   multiplicand on start, then takes WIDTH/2 Booth digits, LSB digit first.
//   Each digit becomes a partial product (0, +-M, +-2M) at weight 4^i, and the
//   partial products are summed into a 2*WIDTH-bit accumulator. When the last
//   digit is accepted, the signed product is offered on prod/prod_valid and
//   held until prod_ready.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high. Digits transfer on dig_valid & dig_ready. The product
//   transfers on prod_valid & prod_ready. When ready is low, valid has no
//   effect. The product side holds prod and prod_valid stable until the
//   transfer.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start, mcand          begin a multiplication (taken only in IDLE)
//   dig_valid, dig_ready  digit handshake
//   single, double, neg,
//   pzero, nzero          Booth digit strobes
//   prod, prod_valid,
//   prod_ready            product handshake
//   busy                  operation in progress (ACCUM or DONE)
//   err                   sticky illegal-digit flag
//   state_dbg             current FSM state, for checkers
//
// Optional feature: define BOOTH_DIGIT_CHECK_EN to flag illegal digit codes
// on err and count those digits as zero. Without it, err is tied low.
module booth_pp_accumulator #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               dig_valid,
  output logic               dig_ready,
  input  logic               single,
  input  logic               double,
  input  logic               neg,
  input  logic               pzero,
  input  logic               nzero,
  output logic [2*WIDTH-1:0] prod,
  output logic               prod_valid,
  input  logic               prod_ready,
  output logic               busy,
  output logic               err,
  output logic [1:0]         state_dbg
);

  localparam int DIGITS = WIDTH / 2;
  localparam int PW     = 2 * WIDTH;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  m_q, m_d;

  // Partial-product decode for the digit currently on the strobes
  logic [PW-1:0]     m_ext;
  logic [PW-1:0]     pp_mag;
  logic [PW-1:0]     pp;
  logic [PW-1:0]     pp_shift;
  logic [PW-1:0]     acc_next;
  logic              digit_zero;
  logic              last_digit;

  assign m_ext      = {{WIDTH{m_q[WIDTH-1]}}, m_q};
  assign pp_mag     = double ? (m_ext << 1) : m_ext;
  assign digit_zero = pzero | nzero | (~single & ~double);
  assign last_digit = (cnt_q == CW'(DIGITS - 1));

`ifdef BOOTH_DIGIT_CHECK_EN
  logic err_q, err_d;
  logic digit_bad;

  assign digit_bad = (single & double) | (pzero & nzero) |
                     ((pzero | nzero) & (single | double)) |
                     (pzero & neg) | (nzero & ~neg);

  always_comb begin
    pp = '0;
    if (!digit_zero && !digit_bad) begin
      pp = neg ? (~pp_mag + PW'(1)) : pp_mag;
    end
  end
`else
  always_comb begin
    pp = '0;
    if (!digit_zero) begin
      pp = neg ? (~pp_mag + PW'(1)) : pp_mag;
    end
  end
`endif

  // Digit i carries weight 4^i, so shift by two bits per position
  assign pp_shift = pp << {cnt_q, 1'b0};
  assign acc_next = acc_q + pp_shift;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
`ifdef BOOTH_DIGIT_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = mcand;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef BOOTH_DIGIT_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (dig_valid) begin
          acc_d = acc_next;
          cnt_d = cnt_q + 1'b1;
`ifdef BOOTH_DIGIT_CHECK_EN
          err_d = err_q | digit_bad;
`endif
          if (last_digit) begin
            prod_d  = acc_next;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (prod_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
    end
  end

`ifdef BOOTH_DIGIT_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign dig_ready  = (state_q == S_ACCUM);
  assign prod_valid = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign prod       = prod_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
module tb_booth_pp_accumulator;

  localparam int WIDTH  = 8;
  localparam int DIGITS = WIDTH / 2;

  logic               clk;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   mcand;
  logic               dig_valid;
  logic               dig_ready;
  logic               single;
  logic               double;
  logic               neg;
  logic               pzero;
  logic               nzero;
  logic [2*WIDTH-1:0] prod;
  logic               prod_valid;
  logic               prod_ready;
  logic               busy;
  logic               err;
  logic [1:0]         state_dbg;

  int n_chk;
  int n_err;
  logic [2*WIDTH-1:0] exp_q[$];

  booth_pp_accumulator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mcand     (mcand),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .single    (single),
    .double    (double),
    .neg       (neg),
    .pzero     (pzero),
    .nzero     (nzero),
    .prod      (prod),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .busy      (busy),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference Booth recoding of multiplier y: strobes {single,double,neg,pzero,nzero}
  function automatic logic [4:0] booth_digit(input logic [WIDTH-1:0] y, input int i);
    logic [WIDTH:0] ext;
    logic [2:0]     t;
    ext = {y, 1'b0};
    t   = ext[2*i+2 -: 3];
    case (t)
      3'b000:          return 5'b00010;
      3'b001, 3'b010:  return 5'b10000;
      3'b011:          return 5'b01000;
      3'b100:          return 5'b01100;
      3'b101, 3'b110:  return 5'b10100;
      default:         return 5'b00101;
    endcase
  endfunction

  task automatic drive_digit(input logic [4:0] d);
    dig_valid = 1'b1;
    {single, double, neg, pzero, nzero} = d;
  endtask

  task automatic clear_digit();
    dig_valid = 1'b0;
    {single, double, neg, pzero, nzero} = 5'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_prod"}, 32'(prod), 32'h0);
    check({tag, "_prod_valid"}, 32'(prod_valid), 32'h0);
    check({tag, "_dig_ready"}, 32'(dig_ready), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
  endtask

  // One full multiplication. bad_digit >= 0 replaces that digit with an
  // illegal single&double code. gap: idle cycles between digits. hold:
  // cycles prod_ready stays low once the product is offered.
  task automatic run_mult(input logic [WIDTH-1:0] mc, input logic [WIDTH-1:0] y,
                          input logic [2*WIDTH-1:0] exp, input int gap, input int hold,
                          input int bad_digit);
    start = 1'b1;
    mcand = mc;
    step();
    start = 1'b0;
    mcand = $urandom_range(0, 255);
    check("accum_busy", 32'(busy), 32'h1);
    check("accum_dig_ready", 32'(dig_ready), 32'h1);
    exp_q.push_back(exp);
    for (int i = 0; i < DIGITS; i++) begin
      if (i == bad_digit) drive_digit(5'b11000);
      else drive_digit(booth_digit(y, i));
      step();
      clear_digit();
      if (i < DIGITS - 1) begin
        check("no_early_valid", 32'(prod_valid), 32'h0);
        for (int g = 0; g < gap; g++) begin
          // Strobes wiggle with dig_valid low: must not be absorbed
          {single, double, neg, pzero, nzero} = 5'($urandom_range(0, 31));
          step();
          check("gap_dig_ready", 32'(dig_ready), 32'h1);
          check("gap_prod_valid", 32'(prod_valid), 32'h0);
        end
        clear_digit();
      end
    end
    check("latency_prod_valid", 32'(prod_valid), 32'h1);
    for (int h = 0; h < hold; h++) begin
      start = (h == 1);
      dig_valid = 1'b1;
      step();
      start = 1'b0;
      dig_valid = 1'b0;
      check("hold_prod_valid", 32'(prod_valid), 32'h1);
      check("hold_busy", 32'(busy), 32'h1);
    end
    prod_ready = 1'b1;
    start = 1'b1;
    step();
    prod_ready = 1'b0;
    start = 1'b0;
    check("after_hs_prod_valid", 32'(prod_valid), 32'h0);
    check("after_hs_busy", 32'(busy), 32'h0);
    check("after_hs_dig_ready", 32'(dig_ready), 32'h0);
  endtask

  // Scoreboard: every cycle the product is offered it must match the head
  // of the expected queue; the entry retires on the handshake.
  always @(negedge clk) begin
    if (!rst && prod_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_prod_valid", 32'(prod_valid), 32'h0);
      end else begin
        check("prod", 32'(prod), 32'(exp_q[0]));
        if (prod_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] rmc;
    logic [WIDTH-1:0] ry;
    n_chk      = 0;
    n_err      = 0;
    rst        = 1'b1;
    start      = 1'b0;
    mcand      = '0;
    prod_ready = 1'b0;
    clear_digit();
    step();
    step();
    check_idle_outputs("reset");
    rst = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'h0);

    // Hand-computed products
    run_mult(8'd7,   8'd3,   16'h0015, 0, 0, -1);
    run_mult(8'h80,  8'h80,  16'h4000, 0, 1, -1);
    run_mult(8'hFB,  8'd6,   16'hFFE2, 2, 0, -1);
    run_mult(8'd7,   8'd3,   16'h0015, 0, 3, -1);
    step();
    check("start_in_done_ignored", 32'(busy), 32'h0);

    // Reset mid-operation abandons the multiplication
    start = 1'b1;
    mcand = 8'd9;
    step();
    start = 1'b0;
    drive_digit(booth_digit(8'd5, 0));
    step();
    drive_digit(booth_digit(8'd5, 1));
    step();
    clear_digit();
    rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    step();
    rst = 1'b0;
    step();
    check("post_rst_idle", 32'(busy), 32'h0);
    run_mult(8'd1, 8'd3, 16'h0003, 0, 0, -1);

`ifdef BOOTH_DIGIT_CHECK_EN
    // Illegal second digit counts as zero: 7 * (-1) = -7
    run_mult(8'd7, 8'd3, 16'hFFF9, 0, 0, 1);
    check("err_set", 32'(err), 32'h1);
    start = 1'b1;
    mcand = 8'd2;
    step();
    start = 1'b0;
    check("err_cleared", 32'(err), 32'h0);
    exp_q.push_back(16'h0008);
    for (int i = 0; i < DIGITS; i++) begin
      drive_digit(booth_digit(8'd4, i));
      step();
    end
    clear_digit();
    prod_ready = 1'b1;
    step();
    prod_ready = 1'b0;
`endif

    // Randomized products against signed multiplication
    for (int k = 0; k < 40; k++) begin
      rmc = WIDTH'($urandom_range(0, 255));
      ry  = WIDTH'($urandom_range(0, 255));
      if (k == 0) begin rmc = 8'h80; ry = 8'h7F; end
      if (k == 1) begin rmc = 8'h7F; ry = 8'h80; end
      if (k == 2) begin rmc = 8'hFF; ry = 8'hFF; end
      run_mult(rmc, ry, 16'($signed(rmc) * $signed(ry)),
               $urandom_range(0, 2), $urandom_range(0, 3), -1);
      check("rand_err_low", 32'(err), 32'h0);
    end

    step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
